rom_read_arbiter: RTL and testbench



---
 rtl/rom_read_arbiter.sv | 117 +++++++++++
 tb/tb_rom_read_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_read_arbiter.sv
// Shares one asynchronous ROM read port between NUM_REQ requesters: arbitrate, one access cycle, registered response.
// Define ROM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); default is round-robin.
module rom_read_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            ack,
    output logic [WIDTH-1:0]              rdata,
    output logic                          busy,
    output logic                          rom_rd_en,
    output logic [ADDR_WIDTH-1:0]         rom_addr,
    input  logic [WIDTH-1:0]              rom_rd_data
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        sel_q, sel_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [IDX_W-1:0]        rr_ptr;
    logic [IDX_W-1:0]        win_idx;
    logic [IDX_W-1:0]        scan_idx;
    logic                    win_found;

    // Wraps at NUM_REQ-1 so non-power-of-two requester counts never visit unused indices.
    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + 1'b1;
    endfunction

`ifdef ROM_ARB_FIXED_PRIO_EN
    assign rr_ptr = '0;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (state_q == RESP) begin
            rr_ptr <= wrap_inc(sel_q);
        end
    end
`endif

    always_comb begin
        // NOTE: every variable driven here gets a default first, otherwise paths that skip an assignment infer a latch.
        win_idx   = '0;
        win_found = 1'b0;
        scan_idx  = rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_found && req[scan_idx]) begin
                win_idx   = scan_idx;
                win_found = 1'b1;
            end
            scan_idx = wrap_inc(scan_idx);
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    sel_d   = win_idx;
                    addr_d  = req_addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                    state_d = ACCESS;
                end
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            addr_q  <= '0;
            rdata   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            if (state_q == ACCESS) begin
                rdata <= rom_rd_data;
            end
        end
    end

    always_comb begin
        ack       = '0;
        rom_rd_en = 1'b0;
        rom_addr  = '0;
        busy      = (state_q != IDLE);
        if (state_q == ACCESS) begin
            rom_rd_en = 1'b1;
            rom_addr  = addr_q;
        end
        if (state_q == RESP) begin
            ack[sel_q] = 1'b1;
        end
    end

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Self-checking bench for rom_read_arbiter: grant-timeline model compared every cycle plus directed literal checks.
module tb_rom_read_arbiter;

    localparam int N  = 3;
    localparam int W  = 32;
    localparam int AW = 10;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    ack;
    logic [W-1:0]    rdata;
    logic            busy;
    logic            rom_rd_en;
    logic [AW-1:0]   rom_addr;
    logic [W-1:0]    rom_rd_data;

    logic [W-1:0]    rom [0:(1<<AW)-1];

    int n_cmp = 0;
    int n_bad = 0;
    bit run   = 1'b0;

    rom_read_arbiter #(.NUM_REQ(N), .WIDTH(W), .ADDR_WIDTH(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_addr    (req_addr),
        .ack         (ack),
        .rdata       (rdata),
        .busy        (busy),
        .rom_rd_en   (rom_rd_en),
        .rom_addr    (rom_addr),
        .rom_rd_data (rom_rd_data)
    );

    assign rom_rd_data = rom[rom_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: every grant is a timestamp; outputs follow from the edge distance since the grant.
    int           m_cyc  = 0;
    int           m_g    = -100;
    int           m_win  = 0;
    int           m_last = -1;
    logic [AW-1:0] m_addr = '0;
    logic [W-1:0]  m_rdata = '0;

    function automatic int pick(input logic [N-1:0] r, input int last);
        int start;
`ifdef ROM_ARB_FIXED_PRIO_EN
        start = 0;
`else
        start = (last < 0) ? 0 : (last + 1) % N;
`endif
        for (int k = 0; k < N; k++) begin
            if (r[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc   = 0;
            m_g     = -100;
            m_last  = -1;
            m_rdata = '0;
        end else begin
            m_cyc++;
            if (m_cyc - m_g == 1) m_rdata = rom[m_addr];
            if (m_cyc - m_g == 2) m_last = m_win;
            if (m_cyc - m_g >= 3 && req != '0) begin
                m_win  = pick(req, m_last);
                m_addr = req_addr[m_win*AW +: AW];
                m_g    = m_cyc;
            end
        end
    end

    always @(negedge clk) begin
        if (run) begin
            int d;
            logic [N-1:0] e_ack;
            d     = m_cyc - m_g;
            e_ack = '0;
            if (d == 1) e_ack[m_win] = 1'b1;
            check("model_ack",       64'(ack),       64'(e_ack));
            check("model_rdata",     64'(rdata),     64'(m_rdata));
            check("model_busy",      64'(busy),      64'(d == 0 || d == 1));
            check("model_rom_rd_en", 64'(rom_rd_en), 64'(d == 0));
            check("model_rom_addr",  64'(rom_addr),  (d == 0) ? 64'(m_addr) : 64'd0);
        end
    end

    task automatic wait_ack(output logic [N-1:0] a, output logic [W-1:0] dat, output int waited);
        a      = '0;
        dat    = '0;
        waited = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            waited++;
            if (ack != '0) begin
                a   = ack;
                dat = rdata;
                return;
            end
        end
        n_cmp++;
        n_bad++;
        $display("FAIL ack_timeout: no ack within 20 cycles, expected one (t=%0t)", $time);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        req = '0;
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    logic [N-1:0] a;
    logic [W-1:0] dat;
    int           waited;

    initial begin
        for (int i = 0; i < (1 << AW); i++) rom[i] = 32'hC0DE0000 + i * 32'h101;
        rom[1]  = 32'h11111111;
        rom[2]  = 32'h22222222;
        rom[3]  = 32'h33333333;
        rom[4]  = 32'h44444444;
        rom[5]  = 32'hDEADBEEF;
        rom[6]  = 32'h66666666;
        rom[7]  = 32'h77777777;
        rom[8]  = 32'h88888888;
        rom[9]  = 32'h99999999;
        rom[12] = 32'hCCCCCCCC;

        rst_n    = 1'b0;
        req      = '0;
        req_addr = '0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        run = 1'b1;

        // Reset values
        @(negedge clk);
        check("rst_ack",   64'(ack),       64'd0);
        check("rst_rdata", 64'(rdata),     64'd0);
        check("rst_busy",  64'(busy),      64'd0);
        check("rst_en",    64'(rom_rd_en), 64'd0);
        check("rst_addr",  64'(rom_addr),  64'd0);

        // Single request from requester 1 at address 5
        req_addr = {10'h003, 10'h005, 10'h000};
        req      = 3'b010;
        @(negedge clk);
        check("single_en",     64'(rom_rd_en), 64'd1);
        check("single_addr",   64'(rom_addr),  64'h5);
        check("single_noack",  64'(ack),       64'd0);
        @(negedge clk);
        check("single_ack",    64'(ack),       64'b010);
        check("single_rdata",  64'(rdata),     64'hDEADBEEF);
        check("single_en_off", 64'(rom_rd_en), 64'd0);
        req = '0;
        @(negedge clk);
        check("single_ack_off", 64'(ack),   64'd0);
        check("single_hold",    64'(rdata), 64'hDEADBEEF);
        check("single_idle",    64'(busy),  64'd0);

        // Simultaneous requests: served 0,1,2 three cycles apart
        pulse_reset();
        req_addr = {10'd3, 10'd2, 10'd1};
        req      = 3'b111;
        for (int k = 0; k < 3; k++) begin
            wait_ack(a, dat, waited);
            check($sformatf("simul_ack%0d", k),   64'(a),      64'(1 << k));
            check($sformatf("simul_data%0d", k),  64'(dat),    64'(32'h11111111 * (k + 1)));
            check($sformatf("simul_gap%0d", k),   64'(waited), (k == 0) ? 64'd2 : 64'd3);
        end
        req = '0;
        repeat (3) @(negedge clk);

        pulse_reset();
        req_addr = {10'd9, 10'd0, 10'd8};
        req      = 3'b101;
`ifdef ROM_ARB_FIXED_PRIO_EN
        // Fixed priority: requester 0 wins every round until it drops
        for (int k = 0; k < 4; k++) begin
            wait_ack(a, dat, waited);
            check($sformatf("prio_ack%0d", k),  64'(a),   64'b001);
            check($sformatf("prio_data%0d", k), 64'(dat), 64'h88888888);
        end
        req = 3'b100;
        wait_ack(a, dat, waited);
        check("prio_ack_r2",  64'(a),   64'b100);
        check("prio_data_r2", 64'(dat), 64'h99999999);
`else
        // Round-robin fairness: 0 and 2 alternate
        for (int k = 0; k < 6; k++) begin
            wait_ack(a, dat, waited);
            check($sformatf("fair_ack%0d", k),  64'(a),   (k % 2 == 0) ? 64'b001 : 64'b100);
            check($sformatf("fair_data%0d", k), 64'(dat), (k % 2 == 0) ? 64'h88888888 : 64'h99999999);
        end
`endif
        req = '0;
        repeat (3) @(negedge clk);

        // Reset mid-access, with a non-zero pointer beforehand
        req_addr = {10'd12, 10'd6, 10'd4};
        req      = 3'b001;
        wait_ack(a, dat, waited);
        check("pre_ack",  64'(a),   64'b001);
        check("pre_data", 64'(dat), 64'h44444444);
        req = '0;
        @(negedge clk);
        req = 3'b010;
        @(negedge clk);
        check("mid_en_before", 64'(rom_rd_en), 64'd1);
        #2 rst_n = 1'b0;
        req = '0;
        #1;
        check("mid_rdata", 64'(rdata),     64'd0);
        check("mid_busy",  64'(busy),      64'd0);
        check("mid_en",    64'(rom_rd_en), 64'd0);
        check("mid_addr",  64'(rom_addr),  64'd0);
        check("mid_ack",   64'(ack),       64'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("mid_noack%0d", k), 64'(ack), 64'd0);
        end
        req = 3'b101;
        wait_ack(a, dat, waited);
        check("post_rst_ack",  64'(a),   64'b001);
        check("post_rst_data", 64'(dat), 64'h44444444);
        req = '0;
        repeat (3) @(negedge clk);

        // Early drop of req[1] during ACCESS; address change must be ignored
        req_addr = {10'd12, 10'd7, 10'd4};
        req      = 3'b010;
        @(negedge clk);
        check("drop_en",   64'(rom_rd_en), 64'd1);
        check("drop_addr", 64'(rom_addr),  64'd7);
        req      = '0;
        req_addr = {10'd12, 10'h3FF, 10'd4};
        @(negedge clk);
        check("drop_ack",   64'(ack),   64'b010);
        check("drop_rdata", 64'(rdata), 64'h77777777);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("drop_noack%0d", k), 64'(ack), 64'd0);
        end

        run = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
